// File: rtl/fpu_q16_divider.sv
// Iterative signed Q16.48 divider, one quotient bit per clock, valid/ready on both sides.
// Quotient truncates toward zero and saturates on overflow; b == 0 raises div_zero.
// Optional build macro FPU_DIV_ROUND_NEAREST_EN: one extra quotient bit is produced and
// the result is rounded half away from zero instead of truncated.
module fpu_q16_divider #(
  parameter int unsigned FRAC_BITS = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        div_zero,
  output logic        overflow
);

  localparam int unsigned IntBits = 64 - FRAC_BITS;
`ifdef FPU_DIV_ROUND_NEAREST_EN
  localparam int unsigned QuoW = 65;
`else
  localparam int unsigned QuoW = 64;
`endif
  localparam logic [6:0]  LastIter = 7'(QuoW - 1);
  localparam logic [63:0] MaxPos   = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MinNeg   = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [63:0]       a_q, a_d;
  logic [63:0]       b_q, b_d;         // raw divisor until PREP, |b| afterwards
  logic              sign_q, sign_d;
  logic [63:0]       rem_q, rem_d;
  logic [63:0]       src_q, src_d;
  logic [QuoW-1:0]   quo_q, quo_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [63:0]       result_q, result_d;
  logic              div_zero_q, div_zero_d;
  logic              overflow_q, overflow_d;

  logic [63:0] a_abs, b_abs;
  logic [64:0] rem_ext;
  logic        rem_ge;
  logic [63:0] rem_sub;
  logic [64:0] mag;

  // Datapath helpers: operand magnitudes, restoring step, final magnitude
  always_comb begin
    a_abs   = a_q[63] ? -a_q : a_q;
    b_abs   = b_q[63] ? -b_q : b_q;
    rem_ext = {rem_q, src_q[63]};
    rem_ge  = rem_ext >= {1'b0, b_q};
    // Difference is below |b| <= 2^63, so the low 64 bits are exact
    rem_sub = rem_ext[63:0] - b_q;
`ifdef FPU_DIV_ROUND_NEAREST_EN
    mag = {1'b0, quo_q[QuoW-1:1]} + 65'(quo_q[0]);
`else
    mag = {1'b0, quo_q};
`endif
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    rem_d      = rem_q;
    src_d      = src_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;
    overflow_d = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = StPrep;
        end
      end
      StPrep: begin
        sign_d = a_q[63] ^ b_q[63];
        b_d    = b_abs;
        if (b_q == 64'd0) begin
          div_zero_d = 1'b1;
          if (a_q == 64'd0)  result_d = 64'd0;
          else if (a_q[63])  result_d = MinNeg;
          else               result_d = MaxPos;
          state_d = StDone;
        end else if (80'(a_abs) >= (80'(b_abs) << IntBits)) begin
          // Quotient magnitude would need more than 64 bits
          overflow_d = 1'b1;
          result_d   = (a_q[63] ^ b_q[63]) ? MinNeg : MaxPos;
          state_d    = StDone;
        end else begin
          rem_d   = a_abs >> IntBits;
          src_d   = a_abs << FRAC_BITS;
          quo_d   = '0;
          cnt_d   = 7'd0;
          state_d = StIter;
        end
      end
      StIter: begin
        src_d = src_q << 1;
        if (rem_ge) begin
          rem_d = rem_sub;
          quo_d = {quo_q[QuoW-2:0], 1'b1};
        end else begin
          rem_d = rem_ext[63:0];
          quo_d = {quo_q[QuoW-2:0], 1'b0};
        end
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == LastIter) state_d = StFix;
      end
      StFix: begin
        if (!sign_q && mag > {1'b0, MaxPos}) begin
          result_d   = MaxPos;
          overflow_d = 1'b1;
        end else if (sign_q && mag > {1'b0, MinNeg}) begin
          result_d   = MinNeg;
          overflow_d = 1'b1;
        end else begin
          result_d = sign_q ? -mag[63:0] : mag[63:0];
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          div_zero_d = 1'b0;
          overflow_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      rem_q      <= '0;
      src_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      rem_q      <= rem_d;
      src_q      <= src_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule
